// File: rtl/tick_gen_pkg.sv
// Shared constants and types for the multi-channel tick generator and its users.
// Divisors are expressed in clk_fpga cycles per tick at 100 MHz.
package tick_gen_pkg;

    localparam int TICK_CNT_W        = 24;
    localparam int DEF_DIV_100M_10HZ = 5_000_000;
    localparam int DIV_1KHZ          = 50_000;

    typedef struct packed {
        logic [TICK_CNT_W-1:0] div;
        logic                  oneshot;
    } tick_cfg_t;

endpackage

// File: rtl/tick_chan.sv
// One rate channel: programmable divisor, periodic or one-shot, with a 1-cycle tick
// strobe and a 50%-duty square wave that toggles on every tick.
module tick_chan #(
    parameter int               CNT_W   = 24,
    parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(5_000_000)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             sync_clr_i,
    input  logic             cfg_we_i,
    input  logic [CNT_W-1:0] cfg_div_i,
    input  logic             cfg_oneshot_i,
    output logic             tick_o,
    output logic             sq_o,
    output logic             busy_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic             oneshot_q, oneshot_d;
    logic             run_q, run_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    logic [CNT_W-1:0] lastCnt;

    // A stored divisor of zero behaves exactly like a divisor of one.
    assign lastCnt = (div_q == '0) ? '0 : div_q - CNT_W'(1);

    always_comb begin
        cnt_d     = cnt_q;
        div_d     = div_q;
        oneshot_d = oneshot_q;
        run_d     = run_q;
        tick_d    = 1'b0;
        sq_d      = sq_q;
        if (sync_clr_i) begin
            cnt_d = '0;
            sq_d  = 1'b0;
        end else if (cfg_we_i) begin
            div_d     = cfg_div_i;
            oneshot_d = cfg_oneshot_i;
            cnt_d     = '0;
            run_d     = 1'b1;
        end else if (en_i && run_q) begin
            if (cnt_q == lastCnt) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                sq_d   = ~sq_q;
                if (oneshot_q) begin
                    run_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            div_q     <= DEF_DIV;
            oneshot_q <= 1'b0;
            run_q     <= 1'b1;
            tick_q    <= 1'b0;
            sq_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            oneshot_q <= oneshot_d;
            run_q     <= run_d;
            tick_q    <= tick_d;
            sq_q      <= sq_d;
        end
    end

    assign tick_o = tick_q;
    assign sq_o   = sq_q;
    assign busy_o = run_q;

endmodule

// File: rtl/tick_gen_multi.sv
// NUM_CH independent tick/square-wave channels clocked from clk_fpga, replacing
// derived clocks with clock enables. Only the config decode lives here.
module tick_gen_multi
    import tick_gen_pkg::*;
#(
    parameter int  NUM_CH  = 4,
    parameter int  CNT_W   = TICK_CNT_W,
    parameter int  DEF_DIV = DEF_DIV_100M_10HZ,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_fpga,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync_clr,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_oneshot,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq,
    output logic [NUM_CH-1:0] busy
);

    logic [NUM_CH-1:0] chWe;

    // Indices at or above NUM_CH match no channel, so such writes vanish.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        assign chWe[i] = cfg_we && (cfg_ch == CH_W'(i));

        tick_chan #(
            .CNT_W   (CNT_W),
            .DEF_DIV (CNT_W'(DEF_DIV))
        ) u_chan (
            .clk_i         (clk_fpga),
            .rst_i         (rst),
            .en_i          (en[i]),
            .sync_clr_i    (sync_clr),
            .cfg_we_i      (chWe[i]),
            .cfg_div_i     (cfg_div),
            .cfg_oneshot_i (cfg_oneshot),
            .tick_o        (tick[i]),
            .sq_o          (sq[i]),
            .busy_o        (busy[i])
        );
    end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Randomised and directed bench for tick_gen_multi against a behavioural model that
// counts qualifying edges since arming; a 3-channel copy exercises out-of-range writes.
module tb_tick_gen_multi;

    localparam int NCH  = 4;
    localparam int CW   = 24;
    localparam int DDIV = 5;

    logic            clk_fpga = 1'b0;
    logic            rst = 1'b1;
    logic [NCH-1:0]  en = '1;
    logic            sync_clr = 1'b0;
    logic            cfg_we = 1'b0;
    logic [1:0]      cfg_ch = '0;
    logic [CW-1:0]   cfg_div = '0;
    logic            cfg_oneshot = 1'b0;
    logic [NCH-1:0]  tick, sq, busy;
    logic [2:0]      tick3, sq3, busy3;

    int total = 0;
    int bad = 0;

    int       mDiv[NCH];
    bit       mOne[NCH];
    bit       mArm[NCH];
    longint   mEdges[NCH];
    logic [NCH-1:0] mTick, mSq;

    always #5 clk_fpga = ~clk_fpga;

    tick_gen_multi #(.NUM_CH(NCH), .CNT_W(CW), .DEF_DIV(DDIV)) u_dut (
        .clk_fpga(clk_fpga), .rst(rst), .en(en), .sync_clr(sync_clr),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_oneshot(cfg_oneshot),
        .tick(tick), .sq(sq), .busy(busy)
    );

    tick_gen_multi #(.NUM_CH(3), .CNT_W(CW), .DEF_DIV(DDIV)) u_dut3 (
        .clk_fpga(clk_fpga), .rst(rst), .en(en[2:0]), .sync_clr(sync_clr),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_oneshot(cfg_oneshot),
        .tick(tick3), .sq(sq3), .busy(busy3)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Tick whenever the number of qualifying edges since arming reaches a multiple of D.
    task automatic modelEdge();
        for (int i = 0; i < NCH; i++) begin
            int eff;
            mTick[i] = 1'b0;
            if (rst) begin
                mDiv[i] = DDIV; mOne[i] = 1'b0; mArm[i] = 1'b1; mEdges[i] = 0; mSq[i] = 1'b0;
            end else if (sync_clr) begin
                mEdges[i] = 0; mSq[i] = 1'b0;
            end else if (cfg_we && int'(cfg_ch) == i) begin
                mDiv[i] = int'(cfg_div); mOne[i] = cfg_oneshot; mArm[i] = 1'b1; mEdges[i] = 0;
            end else if (en[i] && mArm[i]) begin
                eff = (mDiv[i] == 0) ? 1 : mDiv[i];
                mEdges[i]++;
                if (mEdges[i] % eff == 0) begin
                    mTick[i] = 1'b1;
                    mSq[i] = ~mSq[i];
                    if (mOne[i]) mArm[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [NCH-1:0] e, input logic sc,
                                 input logic we, input logic [1:0] ch, input int dv, input logic os);
        logic [NCH-1:0] mBusy;
        @(negedge clk_fpga);
        rst = r; en = e; sync_clr = sc; cfg_we = we; cfg_ch = ch;
        cfg_div = CW'(dv); cfg_oneshot = os;
        @(posedge clk_fpga);
        modelEdge();
        #1;
        for (int i = 0; i < NCH; i++) mBusy[i] = mArm[i];
        checkOutput("tick", 32'(tick), 32'(mTick));
        checkOutput("sq", 32'(sq), 32'(mSq));
        checkOutput("busy", 32'(busy), 32'(mBusy));
        checkOutput("tick3", 32'(tick3), 32'(mTick[2:0]));
        checkOutput("sq3", 32'(sq3), 32'(mSq[2:0]));
        checkOutput("busy3", 32'(busy3), 32'(mBusy[2:0]));
    endtask

    task automatic idle(input logic [NCH-1:0] e);
        applyStimulus(1'b0, e, 1'b0, 1'b0, 2'd0, 0, 1'b0);
    endtask

    task automatic writeCfg(input logic [NCH-1:0] e, input logic [1:0] ch, input int dv, input logic os);
        applyStimulus(1'b0, e, 1'b0, 1'b1, ch, dv, os);
    endtask

    initial begin
        int cnt;
        int n;
        logic [NCH-1:0] e;

        // Reset and free-running default divisor
        applyStimulus(1'b1, 4'hF, 1'b0, 1'b0, 2'd0, 0, 1'b0);
        applyStimulus(1'b1, 4'hF, 1'b0, 1'b0, 2'd0, 0, 1'b0);
        checkOutput("rst_tick", 32'(tick), 32'h0);
        checkOutput("rst_sq", 32'(sq), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'hF);
        for (int k = 1; k <= 15; k++) begin
            idle(4'hF);
            if (k == 4) checkOutput("tick0_e4", 32'(tick[0]), 32'h0);
            if (k == 5) checkOutput("tick0_e5", 32'(tick[0]), 32'h1);
            if (k == 5) checkOutput("sq0_e5", 32'(sq[0]), 32'h1);
            if (k == 10) checkOutput("sq0_e10", 32'(sq[0]), 32'h0);
            if (k == 15) checkOutput("tick0_e15", 32'(tick[0]), 32'h1);
        end
        checkOutput("busy_run", 32'(busy), 32'hF);

        // One-shot on ch2, then re-arm
        writeCfg(4'hF, 2'd2, 3, 1'b1);
        cnt = 0;
        for (int k = 1; k <= 53; k++) begin
            idle(4'hF);
            if (tick[2]) cnt++;
            if (k == 3) checkOutput("os_tick_e3", 32'(tick[2]), 32'h1);
        end
        checkOutput("os_count", 32'(cnt), 32'd1);
        checkOutput("os_busy", 32'(busy[2]), 32'h0);
        writeCfg(4'hF, 2'd2, 3, 1'b1);
        checkOutput("os_rearm_busy", 32'(busy[2]), 32'h1);
        cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            idle(4'hF);
            if (tick[2]) cnt++;
        end
        checkOutput("os_rearm_count", 32'(cnt), 32'd1);

        // Pause ch1 with cnt at 2
        writeCfg(4'hF, 2'd1, 5, 1'b0);
        idle(4'hF);
        idle(4'hF);
        cnt = 0;
        for (int k = 0; k < 7; k++) begin
            idle(4'hD);
            if (tick[1]) cnt++;
        end
        checkOutput("pause_ticks", 32'(cnt), 32'd0);
        idle(4'hF);
        idle(4'hF);
        checkOutput("resume_e2", 32'(tick[1]), 32'h0);
        idle(4'hF);
        checkOutput("resume_e3", 32'(tick[1]), 32'h1);

        // Config write colliding with ch0 terminal count
        writeCfg(4'hF, 2'd0, 5, 1'b0);
        for (int k = 0; k < 4; k++) idle(4'hF);
        writeCfg(4'hF, 2'd0, 4, 1'b0);
        checkOutput("collide_tick", 32'(tick[0]), 32'h0);
        for (int k = 1; k <= 4; k++) begin
            idle(4'hF);
            if (k == 3) checkOutput("collide_e3", 32'(tick[0]), 32'h0);
            if (k == 4) checkOutput("collide_e4", 32'(tick[0]), 32'h1);
        end

        // sync_clr aligns all channels at div 5
        for (int c = 0; c < NCH; c++) writeCfg(4'hF, 2'(c), 5, 1'b0);
        n = $urandom_range(9, 0);
        for (int k = 0; k < n; k++) idle(4'hF);
        applyStimulus(1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 0, 1'b0);
        checkOutput("sync_sq", 32'(sq), 32'h0);
        for (int k = 1; k <= 5; k++) idle(4'hF);
        checkOutput("sync_tick", 32'(tick), 32'hF);
        checkOutput("sync_sq5", 32'(sq), 32'hF);

        // Divisor zero on ch3
        writeCfg(4'hF, 2'd3, 0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            idle(4'hF);
            checkOutput("div0_tick", 32'(tick[3]), 32'h1);
        end

        // Reset mid-count
        idle(4'hF);
        applyStimulus(1'b1, 4'hF, 1'b0, 1'b0, 2'd0, 0, 1'b0);
        checkOutput("rstmid_tick", 32'(tick), 32'h0);
        checkOutput("rstmid_sq", 32'(sq), 32'h0);
        checkOutput("rstmid_busy", 32'(busy), 32'hF);

        // Randomised traffic
        for (int k = 0; k < 1000; k++) begin
            for (int i = 0; i < NCH; i++) e[i] = ($urandom_range(9, 0) < 8);
            if ($urandom_range(199, 0) == 0)
                applyStimulus(1'b1, e, 1'b0, 1'b0, 2'd0, 0, 1'b0);
            else if ($urandom_range(59, 0) == 0)
                applyStimulus(1'b0, e, 1'b1, ($urandom_range(1, 0) == 1), 2'($urandom_range(3, 0)), 2, 1'b0);
            else if ($urandom_range(14, 0) == 0)
                writeCfg(e, 2'($urandom_range(3, 0)), $urandom_range(9, 0), ($urandom_range(3, 0) == 0));
            else
                idle(e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
